// File: rtl/stopwatch_dp.sv
// Stopwatch datapath: time-base divider feeding cascaded centisecond/second/minute/hour counters.
// Optional lap snapshot display is built when STOPWATCH_LAP_EN is defined.
module stopwatch_dp #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int TICK_HZ     = 100,
   parameter int HOUR_MOD    = 24
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i_runstop,
   input  logic       i_clear,
`ifdef STOPWATCH_LAP_EN
   input  logic       i_lap,
   output logic       o_lap_active,
`endif
   output logic [6:0] o_msec,
   output logic [5:0] o_sec,
   output logic [5:0] o_min,
   output logic [4:0] o_hour,
   output logic       o_tick
);

   localparam int DIV   = CLK_FREQ_HZ / TICK_HZ;
   localparam int DIV_W = $clog2(DIV);
   localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(DIV - 1);
   localparam logic [6:0]       MSEC_MAX = 7'd99;
   localparam logic [6:0]       SEC_MAX  = 7'd59;
   localparam logic [6:0]       HOUR_MAX = 7'(HOUR_MOD - 1);

   // Modulo increment shared by every field; exact compare, so out-of-range values are never handled.
   function automatic logic [6:0] wrap_inc(input logic [6:0] val, input logic [6:0] max);
      return (val == max) ? 7'd0 : val + 7'd1;
   endfunction

   logic [DIV_W-1:0] div_cnt_p0;
   logic [6:0]       msec_p0;
   logic [5:0]       sec_p0;
   logic [5:0]       min_p0;
   logic [4:0]       hour_p0;
   logic             tick_p0;

   logic div_wrap;
   logic tick_en;
   logic msec_wrap;
   logic sec_wrap;
   logic min_wrap;

   assign div_wrap  = (div_cnt_p0 == DIV_MAX);
   assign tick_en   = i_runstop & ~i_clear & div_wrap;
   assign msec_wrap = ({1'b0, msec_p0} == {1'b0, MSEC_MAX});
   assign sec_wrap  = ({1'b0, sec_p0} == SEC_MAX);
   assign min_wrap  = ({1'b0, min_p0} == SEC_MAX);

   // Stage p0: divider and cascaded live counters, all carries resolved on the tick edge
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt_p0 <= '0;
         msec_p0    <= '0;
         sec_p0     <= '0;
         min_p0     <= '0;
         hour_p0    <= '0;
         tick_p0    <= 1'b0;
      end else if (i_clear) begin
         div_cnt_p0 <= '0;
         msec_p0    <= '0;
         sec_p0     <= '0;
         min_p0     <= '0;
         hour_p0    <= '0;
         tick_p0    <= 1'b0;
      end else begin
         tick_p0 <= tick_en;
         if (i_runstop)
            div_cnt_p0 <= div_wrap ? '0 : div_cnt_p0 + 1'b1;
         if (tick_en) begin
            msec_p0 <= wrap_inc(msec_p0, MSEC_MAX);
            if (msec_wrap) begin
               sec_p0 <= 6'(wrap_inc({1'b0, sec_p0}, SEC_MAX));
               if (sec_wrap) begin
                  min_p0 <= 6'(wrap_inc({1'b0, min_p0}, SEC_MAX));
                  if (min_wrap)
                     hour_p0 <= 5'(wrap_inc({2'b00, hour_p0}, HOUR_MAX));
               end
            end
         end
      end
   end

`ifdef STOPWATCH_LAP_EN
   logic       lap_active_p1;
   logic [6:0] snap_msec_p1;
   logic [5:0] snap_sec_p1;
   logic [5:0] snap_min_p1;
   logic [4:0] snap_hour_p1;

   // Stage p1: lap snapshot; nonblocking capture takes the pre-increment value on a tick edge
   always @(posedge clk or posedge reset) begin
      if (reset) begin
         lap_active_p1 <= 1'b0;
         snap_msec_p1  <= '0;
         snap_sec_p1   <= '0;
         snap_min_p1   <= '0;
         snap_hour_p1  <= '0;
      end else if (i_clear) begin
         lap_active_p1 <= 1'b0;
         snap_msec_p1  <= '0;
         snap_sec_p1   <= '0;
         snap_min_p1   <= '0;
         snap_hour_p1  <= '0;
      end else if (i_lap) begin
         if (!lap_active_p1) begin
            snap_msec_p1  <= msec_p0;
            snap_sec_p1   <= sec_p0;
            snap_min_p1   <= min_p0;
            snap_hour_p1  <= hour_p0;
            lap_active_p1 <= 1'b1;
         end else begin
            lap_active_p1 <= 1'b0;
         end
      end
   end

   assign o_msec       = lap_active_p1 ? snap_msec_p1 : msec_p0;
   assign o_sec        = lap_active_p1 ? snap_sec_p1  : sec_p0;
   assign o_min        = lap_active_p1 ? snap_min_p1  : min_p0;
   assign o_hour       = lap_active_p1 ? snap_hour_p1 : hour_p0;
   assign o_lap_active = lap_active_p1;
`else
   assign o_msec = msec_p0;
   assign o_sec  = sec_p0;
   assign o_min  = min_p0;
   assign o_hour = hour_p0;
`endif

   assign o_tick = tick_p0;

endmodule

// File: tb/tb_stopwatch_dp.sv
// Directed self-checking bench for stopwatch_dp with DIV = 10.
module tb_stopwatch_dp;

   localparam int CLK_FREQ_HZ = 1000;
   localparam int TICK_HZ     = 100;
   localparam int HOUR_MOD    = 24;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       i_runstop = 1'b0;
   logic       i_clear = 1'b0;
   logic [6:0] o_msec;
   logic [5:0] o_sec;
   logic [5:0] o_min;
   logic [4:0] o_hour;
   logic       o_tick;
`ifdef STOPWATCH_LAP_EN
   logic       i_lap = 1'b0;
   logic       o_lap_active;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   stopwatch_dp #(
      .CLK_FREQ_HZ(CLK_FREQ_HZ),
      .TICK_HZ    (TICK_HZ),
      .HOUR_MOD   (HOUR_MOD)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .i_runstop   (i_runstop),
      .i_clear     (i_clear),
`ifdef STOPWATCH_LAP_EN
      .i_lap       (i_lap),
      .o_lap_active(o_lap_active),
`endif
      .o_msec      (o_msec),
      .o_sec       (o_sec),
      .o_min       (o_min),
      .o_hour      (o_hour),
      .o_tick      (o_tick)
   );

   always #5 clk = ~clk;

   task automatic edges(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      i_runstop = 1'b0;
      i_clear   = 1'b0;
`ifdef STOPWATCH_LAP_EN
      i_lap     = 1'b0;
`endif
      reset = 1'b1;
      edges(2);
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      i_runstop = 1'b1;
      edges(3);
      n_checks++;
      if ({o_hour, o_min, o_sec, o_msec, o_tick} !== 25'd0) begin
         n_fail++;
         $display("FAIL reset_hold: got %0d:%0d:%0d.%0d tick=%0d, want 0:0:0.0 tick=0",
                  o_hour, o_min, o_sec, o_msec, o_tick);
      end
      do_reset();
   endtask

   task automatic test_tick();
      int ticks;
      do_reset();
      i_runstop = 1'b1;
      ticks = 0;
      for (int i = 0; i < 9; i++) begin
         edges(1);
         ticks += int'(o_tick);
      end
      n_checks++;
      if (o_msec !== 7'd0 || ticks != 0) begin
         n_fail++;
         $display("FAIL tick_early: got msec=%0d ticks=%0d, want msec=0 ticks=0", o_msec, ticks);
      end
      edges(1);
      n_checks++;
      if (o_msec !== 7'd1 || o_tick !== 1'b1) begin
         n_fail++;
         $display("FAIL tick_first: got msec=%0d tick=%0d, want msec=1 tick=1", o_msec, o_tick);
      end
      edges(1);
      n_checks++;
      if (o_msec !== 7'd1 || o_tick !== 1'b0) begin
         n_fail++;
         $display("FAIL tick_single: got msec=%0d tick=%0d, want msec=1 tick=0", o_msec, o_tick);
      end
      edges(989);
      n_checks++;
      if ({o_hour, o_min, o_sec, o_msec} !== {5'd0, 6'd0, 6'd1, 7'd0}) begin
         n_fail++;
         $display("FAIL sec_carry: got %0d:%0d:%0d.%0d, want 0:0:1.0", o_hour, o_min, o_sec, o_msec);
      end
   endtask

   task automatic test_pause();
      int ticks;
      do_reset();
      i_runstop = 1'b1;
      edges(5);
      i_runstop = 1'b0;
      ticks = 0;
      for (int i = 0; i < 50; i++) begin
         edges(1);
         ticks += int'(o_tick);
      end
      n_checks++;
      if (o_msec !== 7'd0 || ticks != 0) begin
         n_fail++;
         $display("FAIL pause_hold: got msec=%0d ticks=%0d, want msec=0 ticks=0", o_msec, ticks);
      end
      i_runstop = 1'b1;
      edges(4);
      n_checks++;
      if (o_msec !== 7'd0) begin
         n_fail++;
         $display("FAIL pause_phase_early: got msec=%0d, want 0", o_msec);
      end
      edges(1);
      n_checks++;
      if (o_msec !== 7'd1 || o_tick !== 1'b1) begin
         n_fail++;
         $display("FAIL pause_phase: got msec=%0d tick=%0d, want msec=1 tick=1", o_msec, o_tick);
      end
   endtask

   task automatic test_rollover();
      do_reset();
      dut.hour_p0 = 5'd23;
      dut.min_p0  = 6'd59;
      dut.sec_p0  = 6'd59;
      dut.msec_p0 = 7'd99;
      edges(2);
      n_checks++;
      if ({o_hour, o_min, o_sec, o_msec} !== {5'd23, 6'd59, 6'd59, 7'd99}) begin
         n_fail++;
         $display("FAIL paused_preload: got %0d:%0d:%0d.%0d, want 23:59:59.99", o_hour, o_min, o_sec, o_msec);
      end
      i_runstop = 1'b1;
      edges(9);
      n_checks++;
      if ({o_hour, o_min, o_sec, o_msec} !== {5'd23, 6'd59, 6'd59, 7'd99}) begin
         n_fail++;
         $display("FAIL rollover_early: got %0d:%0d:%0d.%0d, want 23:59:59.99", o_hour, o_min, o_sec, o_msec);
      end
      edges(1);
      n_checks++;
      if ({o_hour, o_min, o_sec, o_msec} !== 24'd0 || o_tick !== 1'b1) begin
         n_fail++;
         $display("FAIL full_rollover: got %0d:%0d:%0d.%0d tick=%0d, want 0:0:0.0 tick=1",
                  o_hour, o_min, o_sec, o_msec, o_tick);
      end

      do_reset();
      dut.sec_p0  = 6'd59;
      dut.msec_p0 = 7'd99;
      i_runstop = 1'b1;
      edges(10);
      n_checks++;
      if ({o_hour, o_min, o_sec, o_msec} !== {5'd0, 6'd1, 6'd0, 7'd0}) begin
         n_fail++;
         $display("FAIL min_carry: got %0d:%0d:%0d.%0d, want 0:1:0.0", o_hour, o_min, o_sec, o_msec);
      end

      do_reset();
      dut.hour_p0 = 5'd5;
      dut.min_p0  = 6'd59;
      dut.sec_p0  = 6'd59;
      dut.msec_p0 = 7'd99;
      i_runstop = 1'b1;
      edges(10);
      n_checks++;
      if ({o_hour, o_min, o_sec, o_msec} !== {5'd6, 6'd0, 6'd0, 7'd0}) begin
         n_fail++;
         $display("FAIL hour_carry: got %0d:%0d:%0d.%0d, want 6:0:0.0", o_hour, o_min, o_sec, o_msec);
      end
   endtask

   task automatic test_clear();
      do_reset();
      i_runstop = 1'b1;
      edges(429);
      n_checks++;
      if (o_msec !== 7'd42) begin
         n_fail++;
         $display("FAIL pre_clear: got msec=%0d, want 42", o_msec);
      end
      i_clear = 1'b1;
      edges(1);
      n_checks++;
      if ({o_hour, o_min, o_sec, o_msec, o_tick} !== 25'd0) begin
         n_fail++;
         $display("FAIL clear_beats_run: got %0d:%0d:%0d.%0d tick=%0d, want 0:0:0.0 tick=0",
                  o_hour, o_min, o_sec, o_msec, o_tick);
      end
      edges(5);
      n_checks++;
      if ({o_hour, o_min, o_sec, o_msec, o_tick} !== 25'd0) begin
         n_fail++;
         $display("FAIL clear_hold: got %0d:%0d:%0d.%0d tick=%0d, want 0:0:0.0 tick=0",
                  o_hour, o_min, o_sec, o_msec, o_tick);
      end
      i_clear = 1'b0;
      edges(9);
      n_checks++;
      if (o_msec !== 7'd0) begin
         n_fail++;
         $display("FAIL clear_div_early: got msec=%0d, want 0", o_msec);
      end
      edges(1);
      n_checks++;
      if (o_msec !== 7'd1 || o_tick !== 1'b1) begin
         n_fail++;
         $display("FAIL clear_div_first: got msec=%0d tick=%0d, want msec=1 tick=1", o_msec, o_tick);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      i_runstop = 1'b1;
      edges(3070);
      n_checks++;
      if ({o_hour, o_min, o_sec, o_msec} !== {5'd0, 6'd0, 6'd3, 7'd7} || o_tick !== 1'b1) begin
         n_fail++;
         $display("FAIL pre_async: got %0d:%0d:%0d.%0d tick=%0d, want 0:0:3.7 tick=1",
                  o_hour, o_min, o_sec, o_msec, o_tick);
      end
      #2;
      reset = 1'b1;
      #1;
      n_checks++;
      if ({o_hour, o_min, o_sec, o_msec, o_tick} !== 25'd0) begin
         n_fail++;
         $display("FAIL async_reset: got %0d:%0d:%0d.%0d tick=%0d, want 0:0:0.0 tick=0",
                  o_hour, o_min, o_sec, o_msec, o_tick);
      end
      edges(1);
      reset = 1'b0;
      edges(9);
      n_checks++;
      if (o_msec !== 7'd0) begin
         n_fail++;
         $display("FAIL post_reset_early: got msec=%0d, want 0", o_msec);
      end
      edges(1);
      n_checks++;
      if (o_msec !== 7'd1) begin
         n_fail++;
         $display("FAIL post_reset_first: got msec=%0d, want 1", o_msec);
      end
   endtask

`ifdef STOPWATCH_LAP_EN
   task automatic test_lap();
      do_reset();
      i_runstop = 1'b1;
      edges(300);
      i_lap = 1'b1;
      edges(1);
      i_lap = 1'b0;
      edges(499);
      n_checks++;
      if (o_msec !== 7'd30 || o_lap_active !== 1'b1) begin
         n_fail++;
         $display("FAIL lap_freeze: got msec=%0d active=%0d, want msec=30 active=1", o_msec, o_lap_active);
      end
      i_lap = 1'b1;
      edges(1);
      i_lap = 1'b0;
      n_checks++;
      if (o_msec !== 7'd80 || o_lap_active !== 1'b0) begin
         n_fail++;
         $display("FAIL lap_release: got msec=%0d active=%0d, want msec=80 active=0", o_msec, o_lap_active);
      end
      edges(8);
      i_lap = 1'b1;
      edges(1);
      i_lap = 1'b0;
      n_checks++;
      if (o_msec !== 7'd80 || o_lap_active !== 1'b1) begin
         n_fail++;
         $display("FAIL lap_on_tick: got msec=%0d active=%0d, want msec=80 active=1", o_msec, o_lap_active);
      end
      i_lap   = 1'b1;
      i_clear = 1'b1;
      edges(1);
      i_lap   = 1'b0;
      i_clear = 1'b0;
      n_checks++;
      if (o_msec !== 7'd0 || o_lap_active !== 1'b0) begin
         n_fail++;
         $display("FAIL clear_beats_lap: got msec=%0d active=%0d, want msec=0 active=0", o_msec, o_lap_active);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_tick();
      test_pause();
      test_rollover();
      test_clear();
      test_async_reset();
`ifdef STOPWATCH_LAP_EN
      test_lap();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
